// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared constants, state encoding and helpers for the sample reader
package lpc_pkg;

    localparam int ADDR_W       = 13;
    localparam int DATA_W       = 16;
    localparam int READ_LATENCY = 1;
    localparam int FIFO_DEPTH   = 4;

    // FIFO occupancy needs one extra bit to represent "full"
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // Occupancy plus reads still in the RAM pipeline
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of reads still travelling through the latency pipe
    function automatic logic [OCC_W-1:0] count_ones(input logic [READ_LATENCY-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lpc_sample_reader_if.sv
// rtl/lpc_sample_reader_if.sv - control, RAM read port and stream signals of the sample reader
interface lpc_sample_reader_if;
    import lpc_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_sop;
    logic              src_eop;

    // Reader side: drives the RAM port and the stream
    modport master (
        input  start, base_addr, length, mem_readdata, src_ready,
        output busy, done, mem_address, mem_chipselect, mem_clken,
               src_data, src_valid, src_sop, src_eop
    );

    // Environment side: software control, RAM and stream sink
    modport slave (
        output start, base_addr, length, mem_readdata, src_ready,
        input  busy, done, mem_address, mem_chipselect, mem_clken,
               src_data, src_valid, src_sop, src_eop
    );

endinterface

// File: rtl/lpc_stream_fifo.sv
// rtl/lpc_stream_fifo.sv - small synchronous FIFO buffering RAM words for the stream
module lpc_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count < CNT_W'(DEPTH)) || w_pop);

    // Head reads as zero when empty so the stream data output idles at zero
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

    // Storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lpc_sample_reader.sv
// rtl/lpc_sample_reader.sv - reads a frame from the sample RAM and streams it with sop/eop framing
module lpc_sample_reader
    import lpc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    lpc_sample_reader_if.master  bus
);
    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W:0]         r_issue_left;
    logic [ADDR_W:0]         r_len;
    logic [ADDR_W:0]         r_beat;
    logic [READ_LATENCY-1:0] r_pipe;
    logic                    r_clken;

    logic [CNT_W-1:0]        w_fifo_count;
    logic [DATA_W-1:0]       w_head;
    logic [OCC_W-1:0]        w_occ;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_valid;
    logic                    w_start_ok;
    logic                    w_last_beat;

    // Reads are only issued when every outstanding word has a guaranteed FIFO slot
    assign w_occ       = OCC_W'(w_fifo_count) + count_ones(r_pipe);
    assign w_issue     = (r_state == FETCH) && (w_occ < OCC_W'(FIFO_DEPTH));
    assign w_push      = r_pipe[READ_LATENCY-1];
    assign w_valid     = (w_fifo_count != '0);
    assign w_pop       = w_valid && bus.src_ready;
    assign w_start_ok  = bus.start && (r_state == IDLE);
    assign w_last_beat = (r_beat == (r_len - (ADDR_W+1)'(1)));

    lpc_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (bus.mem_readdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state: a zero-length start goes straight to DONE without touching the RAM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (bus.start) w_state_next = (bus.length == '0) ? DONE : FETCH;
            FETCH: if (w_issue && (r_issue_left == (ADDR_W+1)'(1))) w_state_next = DRAIN;
            DRAIN: if (w_pop && w_last_beat) w_state_next = DONE;
            DONE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs: status from state, stream straight from the FIFO head
    always_comb begin
        bus.busy           = (r_state != IDLE);
        bus.done           = (r_state == DONE);
        bus.mem_address    = r_addr;
        bus.mem_chipselect = w_issue;
        bus.mem_clken      = r_clken;
        bus.src_data       = w_head;
        bus.src_valid      = w_valid;
        bus.src_sop        = w_valid && (r_beat == '0);
        bus.src_eop        = w_valid && w_last_beat;
    end

    // Frame parameters, address and issue/beat counters; address wraps modulo the RAM size
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_issue_left <= '0;
            r_len        <= '0;
            r_beat       <= '0;
            r_clken      <= 1'b0;
        end else begin
            r_clken <= 1'b1;
            if (w_start_ok) begin
                r_addr       <= bus.base_addr;
                r_issue_left <= bus.length;
                r_len        <= bus.length;
                r_beat       <= '0;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + ADDR_W'(1);
                    r_issue_left <= r_issue_left - (ADDR_W+1)'(1);
                end
                if (w_pop) begin
                    r_beat <= r_beat + (ADDR_W+1)'(1);
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_pipe1
            // Marks the cycle in which RAM readdata belongs to an issued read
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_pipe <= '0;
                else       r_pipe <= w_issue;
            end
        end else begin : g_pipen
            // Shift register tracking issued reads until their data is valid
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_pipe <= '0;
                else       r_pipe <= {r_pipe[READ_LATENCY-2:0], w_issue};
            end
        end
    endgenerate

endmodule

// File: tb/tb_lpc_sample_reader.sv
// tb/tb_lpc_sample_reader.sv - self-checking bench for lpc_sample_reader
module tb_lpc_sample_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lpc_sample_reader_if bus();

    lpc_sample_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] ram [0:8191];
    logic [12:0] ram_addr_q = '0;
    always @(posedge clk) if (bus.mem_clken) ram_addr_q <= bus.mem_address;
    assign bus.mem_readdata = ram[ram_addr_q];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [15:0] got_q[$];
    logic [12:0] addr_q[$];
    int cs_cnt, cs_stall, busy_cnt, done_seen, first_c, last_c, done_c, flag_err, stable_err;

    typedef struct {
        logic [12:0] base;
        int          len;
        int          stall;
        logic [15:0] first;
        logic [15:0] last;
    } vec_t;
    vec_t vecs[6];

    // Runs one frame; starts from just after a negedge, samples each cycle at negedge
    task automatic run_frame(input logic [12:0] base, input int len, input int stall,
                             input int rnd_ready, input int second_start);
        logic        held;
        logic [17:0] held_v;
        int          c;
        got_q.delete(); addr_q.delete();
        cs_cnt = 0; cs_stall = 0; busy_cnt = 0; done_seen = 0;
        first_c = -1; last_c = -1; done_c = -1; flag_err = 0; stable_err = 0;
        held = 1'b0; held_v = '0;
        bus.start = 1'b1; bus.base_addr = base; bus.length = 14'(len);
        @(negedge clk);
        bus.start = 1'b0;
        for (c = 0; c < 20000; c++) begin
            bus.src_ready = (c < stall) ? 1'b0 : (rnd_ready != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
            if (second_start != 0 && c == 3) begin
                bus.start = 1'b1; bus.base_addr = 13'h0100; bus.length = 14'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.mem_chipselect) begin
                cs_cnt++;
                addr_q.push_back(bus.mem_address);
                if (c < stall) cs_stall++;
            end
            if (held) begin
                if (!bus.src_valid || {bus.src_data, bus.src_sop, bus.src_eop} !== held_v) stable_err++;
            end
            held = 1'b0;
            if (bus.src_valid) begin
                if (first_c < 0) first_c = c;
                if (bus.src_sop !== (got_q.size() == 0)) flag_err++;
                if (bus.src_eop !== (got_q.size() == len - 1)) flag_err++;
                if (bus.src_ready) begin
                    got_q.push_back(bus.src_data);
                    last_c = c;
                end else begin
                    held = 1'b1;
                    held_v = {bus.src_data, bus.src_sop, bus.src_eop};
                end
            end
            if (bus.done) begin
                done_seen = 1; done_c = c;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    // Compares the recorded frame with the words the RAM holds at base..base+len-1 (mod 8192)
    task automatic check_frame(input string tag, input logic [12:0] base, input int len);
        int derr, aerr;
        derr = 0; aerr = 0;
        check({tag, " done_seen"}, done_seen, 1);
        check({tag, " beats"}, got_q.size(), len);
        for (int i = 0; i < got_q.size() && i < len; i++)
            if (got_q[i] !== ram[(int'(base) + i) % 8192]) derr++;
        check({tag, " data_errors"}, derr, 0);
        check({tag, " reads"}, cs_cnt, len);
        for (int i = 0; i < addr_q.size() && i < len; i++)
            if (addr_q[i] !== 13'((int'(base) + i) % 8192)) aerr++;
        check({tag, " addr_errors"}, aerr, 0);
        check({tag, " framing_errors"}, flag_err, 0);
        check({tag, " stability_errors"}, stable_err, 0);
        if (len > 0) check({tag, " done_latency"}, done_c, last_c + 1);
        check({tag, " busy_cycles"}, busy_cnt, done_c + 1);
        @(negedge clk);
        check({tag, " idle_after"}, {bus.busy, bus.done, bus.mem_chipselect, bus.src_valid}, 4'b0000);
    endtask

    initial begin
        int   beats;
        logic [12:0] rb;
        int   rl;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.src_ready = 1'b0;
        for (int a = 0; a < 8192; a++) ram[a] = 16'(a);

        vecs[0] = '{13'h0010,    8,  0, 16'h0010, 16'h0017};
        vecs[1] = '{13'h1FFE,    4,  0, 16'h1FFE, 16'h0001};
        vecs[2] = '{13'h0800,   16, 20, 16'h0800, 16'h080F};
        vecs[3] = '{13'h0000,    0,  0, 16'h0000, 16'h0000};
        vecs[4] = '{13'h0123,    1,  0, 16'h0123, 16'h0123};
        vecs[5] = '{13'h0005, 8192,  0, 16'h0005, 16'h0004};

        repeat (2) @(negedge clk);
        check("reset_state",
              {bus.busy, bus.done, bus.mem_address, bus.mem_chipselect, bus.mem_clken,
               bus.src_valid, bus.src_sop, bus.src_eop, bus.src_data}, '0);
        reset = 1'b0;
        @(negedge clk);
        check("clken_after_reset", bus.mem_clken, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].base, vecs[i].len, vecs[i].stall, 0, 0);
            if (vecs[i].len > 0 && got_q.size() > 0) begin
                check($sformatf("vec%0d first_word", i), got_q[0], vecs[i].first);
                check($sformatf("vec%0d last_word", i), got_q[got_q.size()-1], vecs[i].last);
            end
            if (vecs[i].stall == 0 && vecs[i].len > 0)
                check($sformatf("vec%0d first_latency", i), first_c, 2);
            if (vecs[i].stall > 0)
                check($sformatf("vec%0d stall_reads_le_depth", i), cs_stall <= 4, 1'b1);
            check_frame($sformatf("vec%0d", i), vecs[i].base, vecs[i].len);
        end

        // Second start mid-frame must be ignored
        run_frame(13'h0040, 10, 0, 0, 1);
        check_frame("restart_ignored", 13'h0040, 10);

        // Reset while beat 5 of 16 is on the stream
        bus.start = 1'b1; bus.base_addr = 13'h0200; bus.length = 14'd16; bus.src_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        beats = 0;
        for (int c = 0; c < 100 && beats < 5; c++) begin
            if (bus.src_valid && bus.src_ready) beats++;
            @(negedge clk);
        end
        check("reset_reached_beat5", beats, 5);
        check("beat5_data", bus.src_data, 16'h0205);
        #2 reset = 1'b1;
        #1;
        check("midframe_reset_zero",
              {bus.busy, bus.done, bus.mem_address, bus.mem_chipselect, bus.mem_clken,
               bus.src_valid, bus.src_sop, bus.src_eop, bus.src_data}, '0);
        @(negedge clk);
        reset = 1'b0;
        beats = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.done || bus.mem_chipselect || bus.src_valid) beats++;
        end
        check("quiet_after_reset", beats, 0);
        run_frame(13'h0300, 6, 0, 0, 0);
        check_frame("after_reset", 13'h0300, 6);

        // Randomized frames over random RAM contents with random backpressure
        for (int k = 0; k < 6; k++) begin
            for (int a = 0; a < 8192; a++) ram[a] = 16'($urandom);
            rb = (k % 2 == 0) ? 13'($urandom_range(0, 8191)) : 13'($urandom_range(8170, 8191));
            rl = $urandom_range(1, 40);
            run_frame(rb, rl, $urandom_range(0, 6), 1, 0);
            check_frame($sformatf("rand%0d", k), rb, rl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
